// File: rtl/udc_pkg.sv
// Package udc_pkg
// Shared constants for the up/down counter slice.
//   UDC_WIDTH_DEFAULT : default counter width in bits
//   MODE_UP/MODE_DOWN : encodings of the mode (direction) input
package udc_pkg;

  localparam int   UDC_WIDTH_DEFAULT = 8;
  localparam logic MODE_UP           = 1'b1;
  localparam logic MODE_DOWN         = 1'b0;

endpackage

// File: rtl/udc_next_value.sv
// Module udc_next_value
// Combinational next-state logic for the up/down counter.
// Optional feature macro: UDC_TERMINAL_COUNT_EN (adds next_tc output).
// Ports:
//   count      in   WIDTH  current counter value, bit 0 = MSB
//   mode       in   1      1 = count up, 0 = count down
//   ld         in   1      parallel load request
//   d_in       in   WIDTH  load value, bit 0 = MSB
//   clr        in   1      clear request (highest priority)
//   next_count out  WIDTH  value to register on the next edge
//   next_tc    out  1      terminal-count flag for next_count (macro only)
module udc_next_value
  import udc_pkg::*;
#(
  parameter int WIDTH = UDC_WIDTH_DEFAULT
) (
  input  logic [0:WIDTH-1] count,
  input  logic             mode,
  input  logic             ld,
  input  logic [0:WIDTH-1] d_in,
  input  logic             clr,
  output logic [0:WIDTH-1] next_count
`ifdef UDC_TERMINAL_COUNT_EN
  ,
  output logic             next_tc
`endif
);

  // Priority chain: clear beats load, load beats counting. Arithmetic wraps
  // naturally modulo 2^WIDTH because the result is truncated to WIDTH bits.
  always_comb begin
    next_count = count;
    if (clr) begin
      next_count = '0;
    end else if (ld) begin
      next_count = d_in;
    end else if (mode == MODE_UP) begin
      next_count = count + WIDTH'(1);
    end else begin
      next_count = count - WIDTH'(1);
    end
  end

`ifdef UDC_TERMINAL_COUNT_EN
  // The flag is derived from the value about to be registered and the
  // direction sampled on the same edge, so once registered it lines up with
  // count: all-ones while counting up, zero while counting down.
  always_comb begin
    next_tc = 1'b0;
    if (!clr) begin
      if (mode == MODE_UP) begin
        next_tc = (next_count == '1);
      end else begin
        next_tc = (next_count == '0);
      end
    end
  end
`endif

endmodule

// File: rtl/up_down_counter.sv
// Module up_down_counter
// Loadable, synchronously clearable binary up/down counter; all outputs
// registered, no combinational path from inputs to outputs.
// Optional feature macro: UDC_TERMINAL_COUNT_EN (adds registered tc output).
// Ports:
//   clk    in   1      rising-edge clock
//   clr    in   1      synchronous active-high clear, count <= 0
//   ld     in   1      synchronous parallel load of d_in
//   mode   in   1      1 = count up, 0 = count down
//   d_in   in   WIDTH  load value, bit 0 = MSB
//   count  out  WIDTH  registered counter value, bit 0 = MSB
//   tc     out  1      registered terminal count (macro only)
module up_down_counter
  import udc_pkg::*;
#(
  parameter int WIDTH = UDC_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             ld,
  input  logic             mode,
  input  logic [0:WIDTH-1] d_in,
  output logic [0:WIDTH-1] count
`ifdef UDC_TERMINAL_COUNT_EN
  ,
  output logic             tc
`endif
);

  logic [0:WIDTH-1] count_q;
  logic [0:WIDTH-1] count_d;
`ifdef UDC_TERMINAL_COUNT_EN
  logic             tc_q;
  logic             tc_d;
`endif

  udc_next_value #(
    .WIDTH (WIDTH)
  ) u_next_value (
    .count      (count_q),
    .mode       (mode),
    .ld         (ld),
    .d_in       (d_in),
    .clr        (clr),
    .next_count (count_d)
`ifdef UDC_TERMINAL_COUNT_EN
    ,
    .next_tc    (tc_d)
`endif
  );

  // State register. clr is also handled in the next-value logic, but it is
  // kept explicit here so the reset behaviour is visible at the flop.
  always_ff @(posedge clk) begin
    if (clr) begin
      count_q <= '0;
`ifdef UDC_TERMINAL_COUNT_EN
      tc_q    <= 1'b0;
`endif
    end else begin
      count_q <= count_d;
`ifdef UDC_TERMINAL_COUNT_EN
      tc_q    <= tc_d;
`endif
    end
  end

  assign count = count_q;
`ifdef UDC_TERMINAL_COUNT_EN
  assign tc    = tc_q;
`endif

endmodule

// File: tb/tb_up_down_counter.sv
// Testbench tb_up_down_counter
// Drives directed and random traffic into up_down_counter and checks count
// (and tc when UDC_TERMINAL_COUNT_EN is defined) against an arithmetic model.
module tb_up_down_counter;

  logic       clk;
  logic       clr;
  logic       ld;
  logic       mode;
  logic [0:7] d_in;
  logic [0:7] count;
`ifdef UDC_TERMINAL_COUNT_EN
  logic       tc;
`endif

  int total;
  int bad;

  // Reference model: plain integer value kept modulo 256.
  int exp_count;
  bit exp_tc;
  bit model_valid;

  up_down_counter #(.WIDTH(8)) dut (
    .clk   (clk),
    .clr   (clr),
    .ld    (ld),
    .mode  (mode),
    .d_in  (d_in),
    .count (count)
`ifdef UDC_TERMINAL_COUNT_EN
    ,
    .tc    (tc)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Every falling edge, once the model knows the count, compare against it.
  always @(negedge clk) begin
    logic [7:0] act;
    if (model_valid) begin
      act = count;
      total++;
      if ((^act === 1'bx) || (int'(act) != exp_count)) begin
        bad++;
        $display("[TB] FAIL model_count: got %0h want %0h", act, exp_count);
      end
`ifdef UDC_TERMINAL_COUNT_EN
      total++;
      if (tc !== exp_tc) begin
        bad++;
        $display("[TB] FAIL model_tc: got %b want %b (count %0h)", tc, exp_tc, act);
      end
`endif
    end
  end

  // One clock of stimulus: drive inputs, advance the model on the edge,
  // and return just after the falling edge once the compare has run.
  task automatic applyStimulus(input bit c, input bit l, input bit m, input logic [7:0] d);
    clr  = c;
    ld   = l;
    mode = m;
    d_in = d;
    @(posedge clk);
    if (c) begin
      exp_count   = 0;
      exp_tc      = 1'b0;
      model_valid = 1'b1;
    end else begin
      if (l) begin
        exp_count   = int'(d);
        model_valid = 1'b1;
      end else if (m) begin
        exp_count = (exp_count + 1) % 256;
      end else begin
        exp_count = (exp_count + 255) % 256;
      end
      exp_tc = m ? (exp_count == 255) : (exp_count == 0);
    end
    @(negedge clk);
    #1;
  endtask

  // Hand-computed literal expectations that pin the model.
  task automatic checkOutput(input string name, input logic [7:0] want);
    logic [7:0] act;
    act = count;
    total++;
    if (act !== want) begin
      bad++;
      $display("[TB] FAIL %s: got %0h want %0h", name, act, want);
    end
  endtask

`ifdef UDC_TERMINAL_COUNT_EN
  task automatic checkTc(input string name, input logic want);
    total++;
    if (tc !== want) begin
      bad++;
      $display("[TB] FAIL %s: got %b want %b", name, tc, want);
    end
  endtask
`endif

  initial begin
    total       = 0;
    bad         = 0;
    model_valid = 1'b0;
    exp_count   = 0;
    exp_tc      = 1'b0;
    clr  = 1'b0;
    ld   = 1'b0;
    mode = 1'b1;
    d_in = '0;
    @(negedge clk);

    // Reset state
    applyStimulus(1, 0, 1, 8'h00);
    checkOutput("reset", 8'h00);

    // Load then clear, and clear beating load
    applyStimulus(0, 1, 1, 8'd10);
    checkOutput("load10", 8'd10);
    applyStimulus(1, 0, 1, 8'h00);
    checkOutput("clr_from10", 8'h00);
    applyStimulus(1, 1, 1, 8'hAA);
    checkOutput("clr_beats_ld", 8'h00);

    // Up five, down five
    for (int i = 1; i <= 5; i++) begin
      applyStimulus(0, 0, 1, 8'h00);
      checkOutput("count_up", 8'(i));
    end
    for (int i = 4; i >= 0; i--) begin
      applyStimulus(0, 0, 0, 8'h00);
      checkOutput("count_down", 8'(i));
    end

    // Wrap-around both directions
    applyStimulus(0, 1, 1, 8'hFF);
    applyStimulus(0, 0, 1, 8'h00);
    checkOutput("wrap_up", 8'h00);
    applyStimulus(0, 1, 0, 8'h00);
    applyStimulus(0, 0, 0, 8'h00);
    checkOutput("wrap_down", 8'hFF);

    // Load wins over counting
    applyStimulus(0, 1, 1, 8'd7);
    applyStimulus(0, 1, 1, 8'd3);
    checkOutput("ld_priority", 8'd3);
    applyStimulus(0, 0, 1, 8'h00);
    checkOutput("after_ld", 8'd4);

    // Clear mid-count, then resume from zero
    applyStimulus(0, 0, 1, 8'h00);
    applyStimulus(1, 0, 1, 8'h00);
    checkOutput("clr_mid", 8'h00);
    applyStimulus(0, 0, 1, 8'h00);
    checkOutput("resume", 8'h01);

`ifdef UDC_TERMINAL_COUNT_EN
    // Terminal count going up from FD
    applyStimulus(0, 1, 1, 8'hFD);
    checkTc("tc_fd", 1'b0);
    applyStimulus(0, 0, 1, 8'h00);
    checkTc("tc_fe", 1'b0);
    applyStimulus(0, 0, 1, 8'h00);
    checkOutput("tc_up_val", 8'hFF);
    checkTc("tc_ff", 1'b1);
    applyStimulus(0, 0, 1, 8'h00);
    checkTc("tc_00_up", 1'b0);
    // Terminal count going down to 0
    applyStimulus(0, 1, 0, 8'h02);
    applyStimulus(0, 0, 0, 8'h00);
    checkTc("tc_01", 1'b0);
    applyStimulus(0, 0, 0, 8'h00);
    checkOutput("tc_down_val", 8'h00);
    checkTc("tc_00_down", 1'b1);
    applyStimulus(1, 0, 0, 8'h00);
    checkTc("tc_clr", 1'b0);
`endif

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 15) == 0),
                    ($urandom_range(0, 7) == 0),
                    $urandom_range(0, 1) == 1,
                    8'($urandom_range(0, 255)));
    end

    // Random sweeps near the wrap points to exercise tc and modulo arithmetic
    for (int i = 0; i < 20; i++) begin
      applyStimulus(0, 1, $urandom_range(0, 1) == 1,
                    ($urandom_range(0, 1) == 1) ? 8'hFC : 8'h03);
      for (int j = 0; j < 6; j++) begin
        applyStimulus(0, 0, mode, 8'h00);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
